// File: rtl/data_sram_resp_if.sv
// SRAM-like data interface between the EXE-stage initiator and its responder.
// The initiator drives req/wr/size/wstrb/addr/wdata; the responder returns addr_ok/data_ok/rdata.
interface data_sram_resp_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, wstrb, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, wstrb, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/data_sram_resp.sv
// Data-memory responder: byte-strobed word array plus an in-order response queue of fixed latency.
// Optional macro DATA_SRAM_RESP_RANDOM_STALL_EN gates addr_ok with a 16-bit LFSR to defer accepts.
module data_sram_resp #(
  parameter int ADDR_BITS = 10,
  parameter int DEPTH     = 2,
  parameter int LAT       = 2
) (
  input  logic             clk,
  input  logic             reset,
  data_sram_resp_if.slave  sram
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(LAT + 1);

  logic [31:0]          mem [2**ADDR_BITS];
  logic [31:0]          rdata_q [DEPTH];
  logic [AW-1:0]        age_q   [DEPTH];
  logic [DEPTH-1:0]     rd_q;
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] widx;
  logic [31:0]          snap;
  logic                 accept, complete, gate;

  logic unused_bits;
  assign unused_bits = ^{sram.size, sram.addr[31:ADDR_BITS+2], sram.addr[1:0]};

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef DATA_SRAM_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end
  assign gate = lfsr_q[0];
`else
  assign gate = 1'b1;
`endif

  assign widx   = sram.addr[ADDR_BITS+1:2];
  assign snap   = mem[widx];
  assign accept = !reset && sram.req && (cnt_q < CW'(DEPTH)) && gate;
  // Full blocks acceptance even when the head retires this cycle.
  assign complete = !reset && (cnt_q != '0) && (age_q[head_q] == AW'(LAT));

  assign sram.addr_ok = accept;
  assign sram.data_ok = complete;
  assign sram.rdata   = (complete && rd_q[head_q]) ? rdata_q[head_q] : 32'h0;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (accept)   tail_d = nxt(tail_q);
    if (complete) head_d = nxt(head_q);
    case ({accept, complete})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rdata_q[i] <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && tail_q == PW'(i)) begin
          age_q[i]   <= AW'(1);
          rd_q[i]    <= !sram.wr;
          rdata_q[i] <= sram.wr ? 32'h0 : snap;
        end else if (age_q[i] != AW'(LAT)) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

  // Array is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (accept && sram.wr) begin
      for (int b = 0; b < 4; b++)
        if (sram.wstrb[b]) mem[widx][8*b +: 8] <= sram.wdata[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_data_sram_resp.sv
// Directed-vector bench for data_sram_resp (DEPTH=2, LAT=2): handshake, byte writes, ordering, reset.
module tb_data_sram_resp;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  data_sram_resp_if sram();
  data_sram_resp #(.ADDR_BITS(10), .DEPTH(2), .LAT(2)) dut (
    .clk(clk), .reset(reset), .sram(sram));

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ok;
    logic        dok;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(logic req, logic wr, logic [3:0] st, logic [31:0] a,
                              logic [31:0] wd, logic ok, logic dok, logic [31:0] rd);
    vec_t v;
    v.req = req; v.wr = wr; v.wstrb = st; v.addr = a; v.wdata = wd;
    v.ok = ok; v.dok = dok; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic req, input logic wr, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] wd);
    sram.req = req; sram.wr = wr; sram.wstrb = st; sram.addr = a; sram.wdata = wd;
    sram.size = 2'd2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  vec_t tbl [33];

  initial begin
    idle();
    // Reset state: even with req high, nothing is accepted or returned.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
      #1;
      chk("rst_addr_ok", {31'h0, sram.addr_ok}, 32'h0);
      chk("rst_data_ok", {31'h0, sram.data_ok}, 32'h0);
      chk("rst_rdata", sram.rdata, 32'h0);
    end

`ifndef DATA_SRAM_RESP_RANDOM_STALL_EN
    tbl[0]  = mk(1, 1, 4'hF, 32'h100,  32'h11223344, 1, 0, 32'h0);
    tbl[1]  = mk(1, 0, 4'h0, 32'h100,  32'h0,        1, 0, 32'h0);
    tbl[2]  = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h0);
    tbl[3]  = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h11223344);
    tbl[4]  = mk(1, 1, 4'h4, 32'h102,  32'h55555555, 1, 0, 32'h0);
    tbl[5]  = mk(1, 0, 4'h0, 32'h100,  32'h0,        1, 0, 32'h0);
    tbl[6]  = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h0);
    tbl[7]  = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h11553344);
    // Four reads held back-to-back: addr_ok 1,1,0,1,1.
    tbl[8]  = mk(1, 0, 4'h0, 32'h100,  32'h0,        1, 0, 32'h0);
    tbl[9]  = mk(1, 0, 4'h0, 32'h100,  32'h0,        1, 0, 32'h0);
    tbl[10] = mk(1, 0, 4'h0, 32'h100,  32'h0,        0, 1, 32'h11553344);
    tbl[11] = mk(1, 0, 4'h0, 32'h100,  32'h0,        1, 1, 32'h11553344);
    tbl[12] = mk(1, 0, 4'h0, 32'h100,  32'h0,        1, 0, 32'h0);
    tbl[13] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h11553344);
    tbl[14] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h11553344);
    // Read-after-write, then read-before-write.
    tbl[15] = mk(1, 1, 4'hF, 32'h8,    32'hDEADBEEF, 1, 0, 32'h0);
    tbl[16] = mk(1, 0, 4'h0, 32'h8,    32'h0,        1, 0, 32'h0);
    tbl[17] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h0);
    tbl[18] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'hDEADBEEF);
    tbl[19] = mk(1, 0, 4'h0, 32'h8,    32'h0,        1, 0, 32'h0);
    tbl[20] = mk(1, 1, 4'hF, 32'h8,    32'hCAFEF00D, 1, 0, 32'h0);
    tbl[21] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'hDEADBEEF);
    tbl[22] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h0);
    tbl[23] = mk(1, 0, 4'h0, 32'h8,    32'h0,        1, 0, 32'h0);
    tbl[24] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0);
    tbl[25] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'hCAFEF00D);
    // wstrb=0 write still completes but leaves the word alone.
    tbl[26] = mk(1, 1, 4'h0, 32'h8,    32'hFFFFFFFF, 1, 0, 32'h0);
    tbl[27] = mk(1, 0, 4'h0, 32'h8,    32'h0,        1, 0, 32'h0);
    tbl[28] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h0);
    tbl[29] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'hCAFEF00D);
    // Upper address bits and addr[1:0] alias onto word 2.
    tbl[30] = mk(1, 0, 4'h0, 32'h1009, 32'h0,        1, 0, 32'h0);
    tbl[31] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0);
    tbl[32] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'hCAFEF00D);

    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      reset = 1'b0;
      drive(tbl[i].req, tbl[i].wr, tbl[i].wstrb, tbl[i].addr, tbl[i].wdata);
      #1;
      chk($sformatf("v%0d_addr_ok", i), {31'h0, sram.addr_ok}, {31'h0, tbl[i].ok});
      chk($sformatf("v%0d_data_ok", i), {31'h0, sram.data_ok}, {31'h0, tbl[i].dok});
      chk($sformatf("v%0d_rdata", i), sram.rdata, tbl[i].rd);
    end

    // Reset with two reads outstanding: both are dropped.
    @(negedge clk); drive(1'b1, 1'b0, 4'h0, 32'h100, 32'h0); #1;
    chk("mr_acc0", {31'h0, sram.addr_ok}, 32'h1);
    @(negedge clk); drive(1'b1, 1'b0, 4'h0, 32'h8, 32'h0); #1;
    chk("mr_acc1", {31'h0, sram.addr_ok}, 32'h1);
    @(negedge clk); reset = 1'b1; idle(); #1;
    chk("mr_dok_in_rst", {31'h0, sram.data_ok}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); reset = 1'b0; #1;
      chk($sformatf("mr_dok_after%0d", i), {31'h0, sram.data_ok}, 32'h0);
    end
    @(negedge clk); drive(1'b1, 1'b0, 4'h0, 32'h8, 32'h0); #1;
    chk("mr_resume_ok", {31'h0, sram.addr_ok}, 32'h1);
    @(negedge clk); idle(); #1;
    chk("mr_rd_lat1", {31'h0, sram.data_ok}, 32'h0);
    @(negedge clk); #1;
    chk("mr_rd_dok", {31'h0, sram.data_ok}, 32'h1);
    chk("mr_rd_keep", sram.rdata, 32'hCAFEF00D);
`else
    begin
      logic [15:0] lf;
      int          q[$];
      int          cnt;
      logic        e_ok, e_dok;
      lf = 16'hACE1;
      cnt = 0;
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        #1;
        e_ok  = (cnt < 2) && lf[0];
        e_dok = (q.size() != 0) && (q[0] + 2 == c);
        chk($sformatf("st%0d_addr_ok", c), {31'h0, sram.addr_ok}, {31'h0, e_ok});
        chk($sformatf("st%0d_data_ok", c), {31'h0, sram.data_ok}, {31'h0, e_dok});
        if (e_dok) begin void'(q.pop_front()); cnt--; end
        if (e_ok)  begin q.push_back(c); cnt++; end
        lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
      end
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder (slave) end of the core's SRAM-like data interface: the side that answers the EXE stage's req/addr_ok/data_ok transactions.
- Accepts requests, applies byte-strobed writes to an internal word array, returns read data in order after a fixed latency.
- Used as the data memory model behind the pipeline in simulation, and as the reference responder for bring-up and verification of the EXE/MEM handshake.

Parameters:
- ADDR_BITS, 10: word-address width; array holds 2^ADDR_BITS 32-bit words.
- DEPTH, 2: maximum outstanding accepted-but-unanswered transactions (power of two, >=1).
- LAT, 2: cycles from address handshake to data_ok (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1 = write, 0 = read.
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word (informational; wstrb is authoritative).
- data_sram_wstrb  in  4  byte enables for writes.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data, pre-replicated by the initiator.
- data_sram_addr_ok  out  1  request accepted this cycle.
- data_sram_data_ok  out  1  one transaction completes this cycle.
- data_sram_rdata  out  32  read data, valid when data_ok.

Interface fixed: one clock (clk); reset is synchronous and active-high (reset).

Behaviour:
- Handshake: a request is accepted in cycle N iff req && addr_ok in N. addr_ok is combinational: req && (count < DEPTH) [&& stall gate, see Optional Feature].
  - No acceptance when full, even if the head completes in the same cycle.
  - At most one acceptance per cycle.
- Word index = addr[ADDR_BITS+1:2]. addr[1:0] and the upper bits are ignored.
- Write (wr=1) at acceptance: on the clock edge ending cycle N, each byte i with wstrb[i]=1 is updated from wdata[8i+7:8i]. wstrb=0 leaves the array unchanged but still produces a data_ok.
- Read (wr=0) at acceptance: the full 32-bit word is snapshotted into the queue entry in cycle N. It includes every write accepted before N and excludes writes accepted later. Size does not mask rdata; the initiator extracts bytes/halves.
- Queue:
  - In-order FIFO of DEPTH entries {rdata, is_read, age counter}; count is 0..DEPTH.
  - Age starts at 1 at acceptance and increments each cycle, saturating at LAT.
  - Head completes when its age == LAT. data_ok is high in cycle N+LAT for a request accepted in N.
  - Exactly one completion per cycle maximum; responses are strictly in acceptance order.
- data_ok/rdata are combinational from the head entry (registered state). rdata = snapshot for reads, 32'h0 for writes, 32'h0 when data_ok=0.
- Simultaneous accept and complete in one cycle: count unchanged, pointers both advance.
- There is no data-side ready: the initiator must sink data_ok every cycle.
- Reset:
  - count=0, pointers=0, addr_ok=0, data_ok=0, rdata=0.
  - The array is not cleared.
  - Reset asserted mid-transaction drops all outstanding entries; no data_ok is issued for them after reset.
- Pointer wrap: modulo DEPTH. Full = count==DEPTH; empty = count==0.

Optional Feature:
- Macro DATA_SRAM_RESP_RANDOM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to 16'hACE1, advances every cycle.
  - addr_ok is additionally gated by lfsr[0]==1, so accepts are deferred pseudo-randomly.
  - Latency from acceptance to data_ok is unchanged.
- Undefined: no LFSR; addr_ok depends only on req and count.

Test Plan:
- Reset, then write addr=0x100 wdata=0x11223344 wstrb=4'hF, then read 0x100 -> addr_ok same cycle as each req; data_ok 2 cycles after each accept; read rdata=0x11223344, write rdata=0.
- Byte writes: write 0x55 replicated, wstrb=4'b0100 at addr=0x102 over 0x11223344, then read 0x100 -> rdata=0x11553344.
- Back-to-back: 4 reads held every cycle with DEPTH=2, LAT=2 -> addr_ok pattern 1,1,0,1,1 (no accept when full even though head completes); data_ok in order; count never exceeds 2.
- Read-after-write ordering: write 0xDEADBEEF to 0x8 accepted in N, read 0x8 in N+1 -> rdata=0xDEADBEEF. Read accepted in N, then write in N+1 -> read returns the old value.
- Reset asserted while 2 transactions are outstanding -> data_ok=0 on the following cycles, addr_ok resumes immediately; array contents preserved (reread returns the prior value).
- With DATA_SRAM_RESP_RANDOM_STALL_EN: req held high for 64 cycles -> accepts occur only when lfsr[0]=1 (matched against a bench LFSR model seeded 16'hACE1); every accept is followed by data_ok exactly LAT cycles later.
